// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the fetch word record carried from fetch to decode.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        miss;
    logic        illegal;
    logic        invalid;
  } fetch_entry_t;

  localparam int          FETCH_ENTRY_W = $bits(fetch_entry_t);
  localparam logic [31:0] NOP_INSTR     = 32'h0;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch->decode queue bundle: push side from fetch, pop side to decode, plus occupancy status.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_pc;
  logic [31:0]      push_instr;
  logic             push_miss;
  logic             push_illegal;
  logic             push_invalid;

  logic             pop_ready;
  logic             pop_valid;
  logic [31:0]      pop_pc;
  logic [31:0]      pop_instr;
  logic             pop_miss;
  logic             pop_illegal;
  logic             pop_invalid;

  logic [CNT_W-1:0] count;
  logic             almost_full;

  // Pipeline side (fetch producer + decode consumer)
  modport master (
    output push_valid, push_pc, push_instr, push_miss, push_illegal, push_invalid, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_miss, pop_illegal, pop_invalid,
           count, almost_full
  );

  // Queue side
  modport slave (
    input  push_valid, push_pc, push_instr, push_miss, push_illegal, push_invalid, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_miss, pop_illegal, pop_invalid,
           count, almost_full
  );

endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode with single-cycle flush.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FETCH_ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  logic         full;
  logic         empty;
  logic         popValid;
  logic         doPush;
  logic         doPop;
  logic         wrEn;
  logic         rdEn;
  fetch_entry_t pushEntry;
  fetch_entry_t headEntry;
  fetch_entry_t outEntry;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign pushEntry = '{pc:      fq.push_pc,
                       instr:   fq.push_instr,
                       miss:    fq.push_miss,
                       illegal: fq.push_illegal,
                       invalid: fq.push_invalid};
  assign headEntry = fetch_entry_t'(mem[rdPtr]);

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming word straight to decode, unless flushing.
  assign popValid = !empty || (fq.push_valid && !flush);
  assign outEntry = empty ? pushEntry : headEntry;
`else
  assign popValid = !empty;
  assign outEntry = headEntry;
`endif

  assign doPush = fq.push_valid && !full;
  assign doPop  = popValid && fq.pop_ready;

  // A pop while empty can only be a bypassed word: it is consumed without touching storage.
  assign wrEn = doPush && !(empty && doPop);
  assign rdEn = doPop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only; validity is defined entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wrEn && !flush) mem[wrPtr] <= FETCH_ENTRY_W'(pushEntry);
  end

  assign fq.push_ready  = !full;
  assign fq.pop_valid   = popValid;
  assign fq.pop_pc      = popValid ? outEntry.pc      : 32'h0;
  assign fq.pop_instr   = popValid ? outEntry.instr   : NOP_INSTR;
  assign fq.pop_miss    = popValid && outEntry.miss;
  assign fq.pop_illegal = popValid && outEntry.illegal;
  assign fq.pop_invalid = popValid && outEntry.invalid;
  assign fq.count       = count;
  assign fq.almost_full = (count >= CNT_W'(AFULL_LEVEL));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, steady streaming, flush and flag ordering.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   vectors     = 0;
  int   miscompares = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (DEPTH - 1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .fq     (fq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit pv, input logic [31:0] pc, input logic [31:0] instr,
                       input bit miss, input bit pr);
    fq.push_valid   = pv;
    fq.push_pc      = pc;
    fq.push_instr   = instr;
    fq.push_miss    = miss;
    fq.push_illegal = 1'b0;
    fq.push_invalid = 1'b0;
    fq.pop_ready    = pr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flush  = 1'b0;
    resetn = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    #12;
    chk("rst_count",  32'(fq.count), 32'd0);
    chk("rst_pvalid", 32'(fq.pop_valid), 32'd0);
    chk("rst_pready", 32'(fq.push_ready), 32'd1);
    chk("rst_afull",  32'(fq.almost_full), 32'd0);
    chk("rst_instr",  fq.pop_instr, 32'd0);
    resetn = 1'b1;
    tick();

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hbfc00000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0);
      #1;
      chk("fill_pready", 32'(fq.push_ready), 32'd1);
      tick();
      chk("fill_count", 32'(fq.count), 32'(i + 1));
      chk("fill_afull", 32'(fq.almost_full), 32'(i + 1 >= 3));
    end
    drive(1, 32'hdeadbeef, 32'hdead, 0, 0);
    #1;
    chk("full_pready", 32'(fq.push_ready), 32'd0);
    tick();
    chk("drop_count", 32'(fq.count), 32'd4);

    // Drain in order
    drive(0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(fq.pop_valid), 32'd1);
      chk("drain_pc",    fq.pop_pc, 32'hbfc00000 + 32'(4 * i));
      chk("drain_instr", fq.pop_instr, 32'h100 + 32'(i));
      tick();
    end
    #1;
    chk("empty_count", 32'(fq.count), 32'd0);
    chk("empty_valid", 32'(fq.pop_valid), 32'd0);
    chk("empty_instr", fq.pop_instr, 32'd0);
    chk("empty_pc",    fq.pop_pc, 32'd0);
    tick();

    // Steady streaming: one push and one pop every cycle
    for (int k = 0; k < 20; k++) begin
      drive(1, 32'h1000 + 32'(4 * k), 32'(k), 0, 1);
      #1;
      if (k > 0 || BYP) chk("steady_instr", fq.pop_instr, BYP ? 32'(k) : 32'(k - 1));
      else              chk("steady_first", 32'(fq.pop_valid), 32'd0);
      tick();
      chk("steady_count", 32'(fq.count), BYP ? 32'd0 : 32'd1);
    end
    drive(0, 32'h0, 32'h0, 0, 1);
    #1;
    chk("tail_valid", 32'(fq.pop_valid), BYP ? 32'd0 : 32'd1);
    chk("tail_instr", fq.pop_instr, BYP ? 32'd0 : 32'd19);
    tick();
    chk("tail_count", 32'(fq.count), 32'd0);

    // Flush collides with push and pop
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h2000 + 32'(4 * i), 32'h200 + 32'(i), 0, 0);
      tick();
    end
    chk("preflush_count", 32'(fq.count), 32'd2);
    flush = 1'b1;
    drive(1, 32'h0bad0000, 32'hbad, 0, 1);
    tick();
    flush = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("flush_count", 32'(fq.count), 32'd0);
    chk("flush_valid", 32'(fq.pop_valid), 32'd0);
    chk("flush_instr", fq.pop_instr, 32'd0);
    tick();
    chk("flush_hold", 32'(fq.count), 32'd0);

    // Flags travel with their own entry
    drive(1, 32'h003ffffc, 32'h11, 0, 0);
    tick();
    drive(1, 32'h00400000, 32'h22, 1, 0);
    tick();
    drive(1, 32'h00400004, 32'h33, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("flag_pc",   fq.pop_pc, 32'h003ffffc + 32'(4 * i));
      chk("flag_miss", 32'(fq.pop_miss), 32'(i == 1));
      tick();
    end
    #1;
    chk("flag_miss_empty", 32'(fq.pop_miss), 32'd0);
    tick();

    // Asynchronous reset with entries queued
    drive(0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 32'h300 + 32'(i), 0, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0);
    chk("prerst_count", 32'(fq.count), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count",  32'(fq.count), 32'd0);
    chk("arst_valid",  32'(fq.pop_valid), 32'd0);
    chk("arst_instr",  fq.pop_instr, 32'd0);
    chk("arst_pready", 32'(fq.push_ready), 32'd1);
    chk("arst_afull",  32'(fq.almost_full), 32'd0);
    #2;
    resetn = 1'b1;
    tick();
    chk("postrst_valid", 32'(fq.pop_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
